lfsr_stream_decrypter: RTL and testbench

Hardware successor to the software decrypt/depad program. It consumes a stream of parity-tagged, LFSR-encrypted bytes and finds the tap pattern itself from the preamble, searching NPTRN candidates in parallel. It then strips the preamble and the leading spaces, and emits decrypted ASCII with a per-byte parity-error flag. It sits between the data-memory reader and writer in top_level and replaces the decrypt program loop.

---
 rtl/lfsr_stream_decrypter_if.sv | 35 +++
 rtl/lfsr_stream_decrypter.sv | 211 +++++++++++++++++++++
 tb/tb_lfsr_stream_decrypter.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_stream_decrypter_if.sv
// Handshake bundle for the LFSR stream decrypter.
// The master drives requests and input bytes; the slave is the decrypter.
interface lfsr_stream_decrypter_if #(
    parameter int LW    = 7,
    parameter int NPTRN = 9,
    parameter int CW    = 7
);
    localparam int PW = (NPTRN > 1) ? $clog2(NPTRN) : 1;

    logic          req;
    logic          ack;
    logic          in_valid;
    logic          in_ready;
    logic [LW:0]   in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [LW:0]   out_data;
    logic          out_last;
    logic          lock_fail;
    logic [PW-1:0] ptrn_idx;
    logic [CW-1:0] out_count;

    modport master (
        output req, in_valid, in_data, in_last, out_ready,
        input  ack, in_ready, out_valid, out_data, out_last,
        input  lock_fail, ptrn_idx, out_count
    );

    modport slave (
        input  req, in_valid, in_data, in_last, out_ready,
        output ack, in_ready, out_valid, out_data, out_last,
        output lock_fail, ptrn_idx, out_count
    );
endinterface

// File: rtl/lfsr_stream_decrypter.sv
// Stream decrypter: learns the LFSR tap pattern from the preamble,
// strips preamble and leading spaces, emits ASCII with parity flags.
module lfsr_stream_decrypter #(
    parameter int                  LW        = 7,
    parameter int                  NPTRN     = 9,
    parameter logic [NPTRN*LW-1:0] PTRN_LIST = {7'h7B, 7'h7E, 7'h5C,
                                                7'h69, 7'h6A, 7'h72,
                                                7'h78, 7'h48, 7'h60},
    parameter int                  TRAIN     = 8,
    parameter logic [LW-1:0]       OFFSET    = 7'h20,
    parameter int                  CW        = 7
) (
    input logic                   clk,
    input logic                   init,
    lfsr_stream_decrypter_if.slave bus
);
    localparam int PW = (NPTRN > 1) ? $clog2(NPTRN) : 1;
    localparam int TW = $clog2(TRAIN + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_TRAIN, S_STRIP, S_PASS, S_DRAIN, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [LW-1:0]  lfsr_q [NPTRN];
    logic [LW-1:0]  lfsr_d [NPTRN];
    logic [NPTRN-1:0] alive_q, alive_d;
    logic [TW-1:0]  tcnt_q, tcnt_d;
    logic [PW-1:0]  sel_q, sel_d;
    logic [LW:0]    odata_q, odata_d;
    logic           ovalid_q, ovalid_d;
    logic           olast_q, olast_d;
    logic           lfail_q, lfail_d;
    logic           ack_q, ack_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [LW-1:0]    din;
    logic [LW-1:0]    dec;
    logic [LW-1:0]    chr;
    logic             perr;
    logic             in_ready;
    logic             acc;
    logic             ohs;
    logic [NPTRN-1:0] match;
    logic             found;
    logic [PW-1:0]    first;

    function automatic logic [LW-1:0] step(input logic [LW-1:0] s,
                                           input logic [LW-1:0] p);
        return {s[LW-2:0], ^(s & p)};
    endfunction

    assign din  = bus.in_data[LW-1:0];
    assign perr = bus.in_data[LW] != ^din;
    assign dec  = din ^ lfsr_q[sel_q];
    assign chr  = dec + OFFSET;
    assign acc  = bus.in_valid && in_ready;
    assign ohs  = ovalid_q && bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = ovalid_q;
    assign bus.out_data  = odata_q;
    assign bus.out_last  = olast_q;
    assign bus.lock_fail = lfail_q;
    assign bus.ptrn_idx  = sel_q;
    assign bus.out_count = cnt_q;
    assign bus.ack       = ack_q;

    // Input acceptance; PASS stops taking bytes once the last one is held.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            S_TRAIN, S_STRIP, S_DRAIN: in_ready = 1'b1;
            S_PASS:  in_ready = !olast_q && (!ovalid_q || bus.out_ready);
            default: in_ready = 1'b0;
        endcase
    end

    // Candidate survival check and lowest-index survivor.
    always_comb begin
        match = '0;
        found = 1'b0;
        first = '0;
        for (int k = NPTRN - 1; k >= 0; k--) begin
            match[k] = alive_q[k] && (din == lfsr_q[k]) && !perr;
            if (match[k]) begin
                found = 1'b1;
                first = PW'(k);
            end
        end
    end

    // Next-state logic for the control FSM and datapath registers.
    always_comb begin
        state_d  = state_q;
        alive_d  = alive_q;
        tcnt_d   = tcnt_q;
        sel_d    = sel_q;
        odata_d  = odata_q;
        ovalid_d = ovalid_q;
        olast_d  = olast_q;
        lfail_d  = lfail_q;
        ack_d    = ack_q;
        cnt_d    = cnt_q;
        for (int k = 0; k < NPTRN; k++) begin
            lfsr_d[k] = lfsr_q[k];
            if (acc) begin
                lfsr_d[k] = step((state_q == S_TRAIN && tcnt_q == '0)
                                 ? din : lfsr_q[k],
                                 PTRN_LIST[k*LW +: LW]);
            end
        end
        if (ohs) begin
            ovalid_d = 1'b0;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.req) begin
                    state_d = S_TRAIN;
                    alive_d = '0;
                    tcnt_d  = '0;
                    sel_d   = '0;
                    cnt_d   = '0;
                    lfail_d = 1'b0;
                    olast_d = 1'b0;
                    ack_d   = 1'b0;
                end
            end
            S_TRAIN: begin
                if (acc) begin
                    tcnt_d  = tcnt_q + 1'b1;
                    alive_d = (tcnt_q == '0) ? {NPTRN{!perr}} : match;
                    if (bus.in_last) begin
                        lfail_d = 1'b1;
                        ack_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (tcnt_q == TW'(TRAIN - 1)) begin
                        if (found) begin
                            sel_d   = first;
                            state_d = S_STRIP;
                        end else begin
                            lfail_d = 1'b1;
                            state_d = S_DRAIN;
                        end
                    end
                end
            end
            S_STRIP: begin
                if (acc) begin
                    if (dec != '0 || perr) begin
                        odata_d  = {perr, chr};
                        ovalid_d = 1'b1;
                        olast_d  = bus.in_last;
                        state_d  = S_PASS;
                    end else if (bus.in_last) begin
                        ack_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_PASS: begin
                if (acc) begin
                    odata_d  = {perr, chr};
                    ovalid_d = 1'b1;
                    olast_d  = bus.in_last;
                end
                if (ohs && olast_q) begin
                    ack_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DRAIN: begin
                if (acc && bus.in_last) begin
                    ack_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; init aborts the run immediately.
    always_ff @(posedge clk or negedge init) begin
        if (!init) begin
            state_q  <= S_IDLE;
            alive_q  <= '0;
            tcnt_q   <= '0;
            sel_q    <= '0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            olast_q  <= 1'b0;
            lfail_q  <= 1'b0;
            ack_q    <= 1'b0;
            cnt_q    <= '0;
            for (int k = 0; k < NPTRN; k++) lfsr_q[k] <= '0;
        end else begin
            state_q  <= state_d;
            alive_q  <= alive_d;
            tcnt_q   <= tcnt_d;
            sel_q    <= sel_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            olast_q  <= olast_d;
            lfail_q  <= lfail_d;
            ack_q    <= ack_d;
            cnt_q    <= cnt_d;
            for (int k = 0; k < NPTRN; k++) lfsr_q[k] <= lfsr_d[k];
        end
    end
endmodule

// File: tb/tb_lfsr_stream_decrypter.sv
// Scoreboard bench for lfsr_stream_decrypter: encrypts known messages,
// queues the plaintext the decrypter must return, and checks hand values.
module tb_lfsr_stream_decrypter;
    logic clk = 1'b0;
    logic init = 1'b0;

    lfsr_stream_decrypter_if #(.LW(7), .NPTRN(9), .CW(7)) bus ();

    lfsr_stream_decrypter dut (
        .clk  (clk),
        .init (init),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] in_q[$];
    logic [8:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] ref_q[$];
    int  rdy_mode = 0;
    bit  abort = 1'b0;
    bit  drv_done = 1'b0;

    task automatic chk(input string nm, input int act, input int want);
        n_tests++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // Encrypt a 64-byte stream (10-byte zero preamble, message, spaces)
    // and queue the expected output characters.
    task automatic build(input logic [6:0] ptrn, input logic [6:0] seed,
                         input string msg, input int flip_at,
                         input logic [7:0] fmask, input bit expect_out);
        logic [6:0] s;
        logic [6:0] p;
        logic [6:0] e;
        logic [6:0] pd;
        logic [7:0] b;
        logic       pe;
        bit         lead;
        s = seed;
        lead = 1'b1;
        in_q.delete();
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < 64; i++) begin
            if (i < 10) p = 7'h00;
            else if (i - 10 < msg.len()) p = 7'(msg[i-10]) - 7'h20;
            else p = 7'h00;
            e = p ^ s;
            b = {^e, e};
            if (i == flip_at) b = b ^ fmask;
            in_q.push_back(b);
            pe = b[7] != ^b[6:0];
            pd = (i == flip_at) ? (p ^ fmask[6:0]) : p;
            if (expect_out && i >= 8) begin
                if (lead && (pd != 7'h00 || pe)) lead = 1'b0;
                if (!lead)
                    exp_q.push_back({(i == 63), pe, 7'(pd + 7'h20)});
            end
            s = {s[5:0], ^(s & ptrn)};
        end
    endtask

    task automatic drive_stream();
        int  i;
        int  guard;
        bit  hs;
        i = 0;
        guard = 0;
        while (i < in_q.size() && guard < 3000 && !abort) begin
            bus.in_valid = 1'b1;
            bus.in_data  = in_q[i];
            bus.in_last  = (i == in_q.size() - 1);
            @(negedge clk);
            hs = bus.in_ready;
            @(posedge clk);
            #1;
            if (hs) i++;
            guard++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (guard >= 3000) chk("drive_timeout", guard, 0);
    endtask

    task automatic pulse_req();
        bus.req = 1'b1;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
    endtask

    task automatic wait_ack();
        int n;
        n = 0;
        while (!bus.ack && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("ack", int'(bus.ack), 1);
    endtask

    function automatic int first_out();
        return (got_q.size() > 0) ? int'(got_q[0]) : -1;
    endfunction

    // out_ready driver: always 1, or the 1,0,0,1 stall pattern.
    initial begin
        bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int c;
        c = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = (rdy_mode == 0) ? 1'b1 : pat[c % 4];
            c++;
        end
    end

    // Monitor: pops on every output handshake, checks stall stability.
    initial begin
        bit         prev_stall;
        logic [7:0] prev_data;
        logic [8:0] e;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (!init) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", int'(bus.out_valid), 1);
                    chk("stall_data", int'(bus.out_data), int'(prev_data));
                end
                if (bus.out_valid && bus.out_ready) begin
                    got_q.push_back(bus.out_data);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", int'(bus.out_data), -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_byte", int'({bus.out_last, bus.out_data}),
                            int'(e));
                    end
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_data  = bus.out_data;
            end
        end
    end

    initial begin
        string m1;
        string m2;
        int    mism;
        m1 = "Mr. Watson, come here. I want to see you.";
        m2 = "  Knowledge is power.";
        bus.req = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_last = 1'b0;

        #1;
        chk("rst_ack", int'(bus.ack), 0);
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_lock_fail", int'(bus.lock_fail), 0);
        chk("rst_out_count", int'(bus.out_count), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        repeat (2) @(negedge clk);
        init = 1'b1;
        @(posedge clk);
        #1;

        // Run 1: pattern 0x60, seed 0x01
        build(7'h60, 7'h01, m1, -1, 8'h00, 1'b1);
        pulse_req();
        drive_stream();
        wait_ack();
        chk("t1_ptrn_idx", int'(bus.ptrn_idx), 0);
        chk("t1_lock_fail", int'(bus.lock_fail), 0);
        chk("t1_out_count", int'(bus.out_count), 54);
        chk("t1_first", first_out(), 'h4D);
        chk("t1_left", exp_q.size(), 0);
        ref_q = got_q;

        // Run 2: pattern 0x7B, seed 0x55, leading spaces stripped
        @(posedge clk);
        #1;
        build(7'h7B, 7'h55, m2, -1, 8'h00, 1'b1);
        pulse_req();
        chk("t2_ack_clear", int'(bus.ack), 0);
        drive_stream();
        wait_ack();
        chk("t2_ptrn_idx", int'(bus.ptrn_idx), 8);
        chk("t2_lock_fail", int'(bus.lock_fail), 0);
        chk("t2_out_count", int'(bus.out_count), 52);
        chk("t2_first", first_out(), 'h4B);
        chk("t2_left", exp_q.size(), 0);

        // Run 3: bit 3 flipped in byte 30 ('e' -> parity flag + 'm')
        @(posedge clk);
        #1;
        build(7'h60, 7'h01, m1, 30, 8'h08, 1'b1);
        pulse_req();
        drive_stream();
        wait_ack();
        chk("t3_out_count", int'(bus.out_count), 54);
        chk("t3_flip", (got_q.size() > 20) ? int'(got_q[20]) : -1, 'hED);
        chk("t3_left", exp_q.size(), 0);

        // Run 4: corrupted preamble byte 4 -> lock failure, drain
        @(posedge clk);
        #1;
        build(7'h60, 7'h01, m1, 4, 8'h01, 1'b0);
        pulse_req();
        drive_stream();
        wait_ack();
        chk("t4_lock_fail", int'(bus.lock_fail), 1);
        chk("t4_out_count", int'(bus.out_count), 0);
        chk("t4_no_out", got_q.size(), 0);

        // Run 5: out_ready toggling 1,0,0,1
        @(posedge clk);
        #1;
        rdy_mode = 1;
        build(7'h60, 7'h01, m1, -1, 8'h00, 1'b1);
        pulse_req();
        drive_stream();
        wait_ack();
        rdy_mode = 0;
        chk("t5_out_count", int'(bus.out_count), 54);
        chk("t5_first", first_out(), 'h4D);
        chk("t5_left", exp_q.size(), 0);

        // Run 6: reset mid-PASS, then identical rerun
        @(posedge clk);
        #1;
        build(7'h60, 7'h01, m1, -1, 8'h00, 1'b1);
        pulse_req();
        abort = 1'b0;
        drv_done = 1'b0;
        fork
            begin
                drive_stream();
                drv_done = 1'b1;
            end
        join_none
        begin
            int n;
            n = 0;
            while (got_q.size() < 20 && n < 500) begin
                @(negedge clk);
                n++;
            end
            chk("t6_reach_pass", int'(got_q.size() >= 20), 1);
        end
        @(posedge clk);
        #3;
        init = 1'b0;
        #1;
        chk("t6_ack", int'(bus.ack), 0);
        chk("t6_in_ready", int'(bus.in_ready), 0);
        chk("t6_out_valid", int'(bus.out_valid), 0);
        chk("t6_out_last", int'(bus.out_last), 0);
        chk("t6_ptrn_idx", int'(bus.ptrn_idx), 0);
        chk("t6_out_count", int'(bus.out_count), 0);
        chk("t6_out_data", int'(bus.out_data), 0);
        abort = 1'b1;
        begin
            int n;
            n = 0;
            while (!drv_done && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("t6_drv_stop", int'(drv_done), 1);
        end
        abort = 1'b0;
        @(negedge clk);
        init = 1'b1;
        @(posedge clk);
        #1;
        build(7'h60, 7'h01, m1, -1, 8'h00, 1'b1);
        pulse_req();
        drive_stream();
        wait_ack();
        chk("t6_rerun_count", int'(bus.out_count), 54);
        chk("t6_rerun_size", got_q.size(), ref_q.size());
        mism = 0;
        for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
            if (got_q[i] != ref_q[i]) mism++;
        chk("t6_rerun_same", mism, 0);
        chk("t6_left", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
